// File: rtl/dsp_mac_sequencer.sv
// Purpose : runs an N-element dot product on an external MAC unit, fetching A/B operand pairs and writing the final sum.
// Latency : 3 cycles per element with zero-wait memory, plus one write cycle and one done cycle (done in cycle 3N+2).
// Backpres: every memory request is held (stable address/data) until mem_valid; each wait cycle adds one cycle.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, src_a_base, src_b_base,  job request and job parameters, sampled only in IDLE
//   dst_addr, length, mode_cfg
//   busy, done, ovf_sticky          job status (done is a one-cycle pulse)
//   mem_*                           single-request memory port (read or write, completed by mem_valid)
//   mac_*                           MAC operands/strobe out, combinational result and flags in
//   abort                           only present when DSP_SEQ_ABORT_EN is defined; drops the job back to IDLE
module dsp_mac_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_a_base,
    input  logic [ADDR_WIDTH-1:0] src_b_base,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [1:0]            mode_cfg,
`ifdef DSP_SEQ_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  ovf_sticky,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic                  mem_valid,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    output logic [DATA_WIDTH-1:0] mac_c,
    output logic [1:0]            mac_mode,
    output logic                  mac_enable,
    input  logic [DATA_WIDTH-1:0] mac_result,
    input  logic                  mac_overflow,
    input  logic                  mac_underflow
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_MAC  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_a_q, src_a_d;
    logic [ADDR_WIDTH-1:0] src_b_q, src_b_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [1:0]            mode_q, mode_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic                  ovf_q, ovf_d;

    // Word offset of the current element; bits shifted past the top are
    // dropped, so base+offset wraps modulo 2^ADDR_WIDTH.
    logic [ADDR_WIDTH-1:0] idx_off;
    assign idx_off = ADDR_WIDTH'(idx_q) << 2;

    assign ovf_sticky = ovf_q;
    assign mac_mode   = mode_q;

    always_comb begin
        state_d      = state_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        dst_d        = dst_q;
        len_d        = len_q;
        mode_d       = mode_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        ovf_d        = ovf_q;
        busy         = (state_q != S_IDLE);
        done         = 1'b0;
        mem_addr     = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_data_out = '0;
        mac_a        = '0;
        mac_b        = '0;
        mac_c        = '0;
        mac_enable   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_a_d = src_a_base;
                    src_b_d = src_b_base;
                    dst_d   = dst_addr;
                    len_d   = length;
                    mode_d  = mode_cfg;
                    idx_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    // An empty job still writes the (zero) accumulator.
                    state_d = (length == '0) ? S_WR : S_RD_A;
                end
            end
            S_RD_A: begin
                mem_read = 1'b1;
                mem_addr = src_a_q + idx_off;
                if (mem_valid) begin
                    op_a_d  = mem_data_in;
                    state_d = S_RD_B;
                end
            end
            S_RD_B: begin
                mem_read = 1'b1;
                mem_addr = src_b_q + idx_off;
                if (mem_valid) begin
                    op_b_d  = mem_data_in;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                mac_enable = 1'b1;
                mac_a      = op_a_q;
                mac_b      = op_b_q;
                mac_c      = acc_q;
                acc_d      = mac_result;
                ovf_d      = ovf_q | mac_overflow | mac_underflow;
                idx_d      = idx_q + LEN_WIDTH'(1);
                // len_q is non-zero here, so len_q-1 cannot underflow.
                state_d    = (idx_q == len_q - LEN_WIDTH'(1)) ? S_WR : S_RD_A;
            end
            S_WR: begin
                mem_write    = 1'b1;
                mem_addr     = dst_q;
                mem_data_out = acc_q;
                if (mem_valid) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef DSP_SEQ_ABORT_EN
        // Abort wins over everything: strobes are suppressed in the abort
        // cycle so no write or MAC update can land, and the sticky flag and
        // datapath registers keep their values.
        if (abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            idx_d        = idx_q;
            acc_d        = acc_q;
            op_a_d       = op_a_q;
            op_b_d       = op_b_q;
            ovf_d        = ovf_q;
            done         = 1'b0;
            mem_addr     = '0;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            mem_data_out = '0;
            mac_a        = '0;
            mac_b        = '0;
            mac_c        = '0;
            mac_enable   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            mode_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
`timescale 1ns/1ps
module tb_dsp_mac_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [31:0] src_a_base, src_b_base, dst_addr;
    logic [7:0]  length;
    logic [1:0]  mode_cfg;
    logic        busy, done, ovf_sticky;
    logic [31:0] mem_addr;
    logic        mem_read, mem_write;
    logic [31:0] mem_data_out, mem_data_in;
    logic        mem_valid;
    logic [31:0] mac_a, mac_b, mac_c, mac_result;
    logic [1:0]  mac_mode;
    logic        mac_enable, mac_overflow, mac_underflow;
`ifdef DSP_SEQ_ABORT_EN
    logic        abort;
`endif

    // Memory model: 64 words, reads may stall `stall` cycles, writes are zero-wait.
    logic [31:0] mem_arr [0:63];
    int          stall = 0;
    int          wait_cnt = 0;
    logic        ovf_inj = 1'b0;

    assign mem_valid   = mem_write | (mem_read && (wait_cnt >= stall));
    assign mem_data_in = mem_read ? mem_arr[mem_addr[7:2]] : 32'd0;

    // Behavioural MAC; overflow injected on the element whose A operand is 2.
    assign mac_result    = mac_a * mac_b + mac_c;
    assign mac_overflow  = ovf_inj && mac_enable && (mac_a == 32'd2);
    assign mac_underflow = 1'b0;

    // Event monitors
    int          wr_cnt = 0, rd_cnt = 0, mac_cnt = 0, done_cnt = 0;
    logic [31:0] wr_data_l = '0;
    logic [31:0] prev_addr = '0;
    logic        prev_pend = 1'b0;
    logic        unstable = 1'b0;

    always @(posedge clk) begin
        if (mem_read && !mem_valid) wait_cnt <= wait_cnt + 1;
        else                        wait_cnt <= 0;
        if (mem_write && mem_valid) begin
            wr_cnt    <= wr_cnt + 1;
            wr_data_l <= mem_data_out;
        end
        if (mem_read)   rd_cnt   <= rd_cnt + 1;
        if (mac_enable) mac_cnt  <= mac_cnt + 1;
        if (done)       done_cnt <= done_cnt + 1;
        if (prev_pend && mem_read && (mem_addr != prev_addr)) unstable <= 1'b1;
        if (mem_read && !mem_valid) begin
            prev_addr <= mem_addr;
            prev_pend <= 1'b1;
        end else begin
            prev_pend <= 1'b0;
        end
    end

    dsp_mac_sequencer #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .LEN_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .src_a_base   (src_a_base),
        .src_b_base   (src_b_base),
        .dst_addr     (dst_addr),
        .length       (length),
        .mode_cfg     (mode_cfg),
`ifdef DSP_SEQ_ABORT_EN
        .abort        (abort),
`endif
        .busy         (busy),
        .done         (done),
        .ovf_sticky   (ovf_sticky),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_valid    (mem_valid),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_c        (mac_c),
        .mac_mode     (mac_mode),
        .mac_enable   (mac_enable),
        .mac_result   (mac_result),
        .mac_overflow (mac_overflow),
        .mac_underflow(mac_underflow)
    );

    int total = 0;
    int bad   = 0;
    int cur   = 0;
    int wr0, rd0, mac0, done0;

    localparam logic [31:0] A_BASE = 32'h0000_0000;
    localparam logic [31:0] B_BASE = 32'h0000_0080;
    localparam logic [31:0] DST    = 32'h0000_1000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sampling happens on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cur++;
    endtask

    task automatic goto(input int k);
        while (cur < k) step();
    endtask

    // Called at a falling edge with the DUT idle; returns in cycle 1 of the job.
    task automatic start_job(input logic [7:0] n, input logic [1:0] m);
        src_a_base = A_BASE;
        src_b_base = B_BASE;
        dst_addr   = DST;
        length     = n;
        mode_cfg   = m;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cur   = 1;
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0;
        src_a_base = '0; src_b_base = '0; dst_addr = '0; length = '0; mode_cfg = '0;
`ifdef DSP_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        for (int i = 0; i < 64; i++) mem_arr[i] = 32'd0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_strobes", {busy, done, ovf_sticky, mem_read, mem_write, mac_enable, mac_mode}, 64'd0);
        chk("reset_addr", mem_addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- N=3 dot product, zero-wait: 1*4+2*5+3*6 = 32 ----
        mem_arr[0] = 1;  mem_arr[1] = 2;  mem_arr[2] = 3;
        mem_arr[32] = 4; mem_arr[33] = 5; mem_arr[34] = 6;
        wr0 = wr_cnt;
        start_job(8'd3, 2'd1);
        chk("n3_c1_busy_rd", {busy, mem_read, mem_write}, 64'b110);
        chk("n3_c1_addr", mem_addr, A_BASE);
        chk("n3_mode", mac_mode, 64'd1);
        goto(2);
        chk("n3_c2_addr", mem_addr, B_BASE);
        goto(3);
        chk("n3_c3_mac", {mac_enable, mem_read, mac_a[7:0], mac_b[7:0], mac_c[7:0]}, {2'b10, 8'd1, 8'd4, 8'd0});
        goto(4);
        chk("n3_c4_addr", mem_addr, A_BASE + 4);
        goto(9);
        chk("n3_c9_mac", {mac_enable, mac_a[7:0], mac_b[7:0], mac_c[7:0]}, {1'b1, 8'd3, 8'd6, 8'd14});
        goto(10);
        chk("n3_c10_wr", {mem_write, mem_read, done}, 64'b100);
        chk("n3_c10_addr", mem_addr, DST);
        chk("n3_c10_data", mem_data_out, 64'd32);
        goto(11);
        chk("n3_c11_done", {done, busy, ovf_sticky}, 64'b110);
        goto(12);
        chk("n3_c12_idle", {done, busy}, 64'b00);
        chk("n3_wr_count", wr_cnt - wr0, 64'd1);
        chk("n3_wr_data", wr_data_l, 64'd32);

        // ---- N=0: immediate write of zero, no reads or MACs ----
        wr0 = wr_cnt; rd0 = rd_cnt; mac0 = mac_cnt;
        start_job(8'd0, 2'd0);
        chk("n0_c1_wr", {mem_write, mem_read, busy}, 64'b101);
        chk("n0_c1_addr", mem_addr, DST);
        chk("n0_c1_data", mem_data_out, 64'd0);
        goto(2);
        chk("n0_c2_done", done, 64'd1);
        goto(3);
        chk("n0_no_rd_mac", {rd_cnt - rd0, mac_cnt - mac0}, 64'd0);
        chk("n0_wr_count", wr_cnt - wr0, 64'd1);

        // ---- N=2, every read stalls 2 cycles: 5*7+6*8 = 83, done in cycle 16 ----
        mem_arr[0] = 5;  mem_arr[1] = 6;
        mem_arr[32] = 7; mem_arr[33] = 8;
        stall = 2;
        start_job(8'd2, 2'd0);
        chk("st_c1", {mem_read, mem_valid}, 64'b10);
        chk("st_c1_addr", mem_addr, A_BASE);
        goto(2);
        chk("st_c2_addr", mem_addr, A_BASE);
        goto(3);
        chk("st_c3", {mem_read, mem_valid}, 64'b11);
        chk("st_c3_addr", mem_addr, A_BASE);
        goto(4);
        chk("st_c4_addr", mem_addr, B_BASE);
        goto(7);
        chk("st_c7_mac", {mac_enable, mac_a[7:0], mac_b[7:0]}, {1'b1, 8'd5, 8'd7});
        goto(8);
        chk("st_c8_addr", mem_addr, A_BASE + 4);
        goto(15);
        chk("st_c15_wr", {mem_write, mem_data_out}, {1'b1, 32'd83});
        goto(16);
        chk("st_c16_done", done, 64'd1);
        chk("st_addr_stable", unstable, 64'd0);
        stall = 0;
        goto(17);

        // ---- Overflow on element 1 of 4: 1+2+3+4 = 10 ----
        for (int i = 0; i < 4; i++) begin
            mem_arr[i]      = i + 1;
            mem_arr[32 + i] = 1;
        end
        ovf_inj = 1'b1;
        start_job(8'd4, 2'd3);
        goto(6);
        chk("ov_c6_pre", {mac_enable, mac_overflow, ovf_sticky}, 64'b110);
        goto(7);
        chk("ov_c7_set", ovf_sticky, 64'd1);
        goto(13);
        chk("ov_c13_wr", {mem_write, mem_data_out}, {1'b1, 32'd10});
        goto(14);
        chk("ov_c14_done", {done, ovf_sticky}, 64'b11);
        goto(15);
        chk("ov_c15_hold", {busy, ovf_sticky}, 64'b01);
        ovf_inj = 1'b0;
        start_job(8'd0, 2'd0);
        chk("ov_cleared", ovf_sticky, 64'd0);
        goto(3);

        // ---- Reset during RD_B of element 2, then N=1 job (3*4 = 12) ----
        for (int i = 0; i < 4; i++) begin
            mem_arr[i]      = i + 1;
            mem_arr[32 + i] = i + 5;
        end
        wr0 = wr_cnt;
        start_job(8'd4, 2'd2);
        goto(8);
        chk("rs_c8_rdb", {mem_read, mac_mode}, {1'b1, 2'd2});
        chk("rs_c8_addr", mem_addr, B_BASE + 8);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_async_strobes", {busy, done, ovf_sticky, mem_read, mem_write, mac_enable, mac_mode}, 64'd0);
        chk("rs_async_addr", mem_addr, 64'd0);
        chk("rs_async_data", mac_a | mac_b | mac_c | mem_data_out, 64'd0);
        repeat (4) step();
        chk("rs_no_write", wr_cnt - wr0, 64'd0);
        rst_n = 1'b1;
        step();
        mem_arr[0] = 3; mem_arr[32] = 4;
        start_job(8'd1, 2'd0);
        goto(4);
        chk("rs_n1_wr", {mem_write, mem_data_out}, {1'b1, 32'd12});
        goto(5);
        chk("rs_n1_done", done, 64'd1);
        goto(6);

`ifdef DSP_SEQ_ABORT_EN
        // ---- Abort in MAC of element 1 of N=4 ----
        wr0 = wr_cnt; done0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            mem_arr[i]      = i + 1;
            mem_arr[32 + i] = 1;
        end
        start_job(8'd4, 2'd0);
        goto(6);
        chk("ab_c6_mac", mac_enable, 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_idle", {busy, mem_read, mem_write, mac_enable}, 64'd0);
        repeat (20) step();
        chk("ab_no_write", wr_cnt - wr0, 64'd0);
        chk("ab_no_done", done_cnt - done0, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Sequencer that runs a length-N dot product on the DSP MAC unit without CPU involvement. It fetches operand pairs from two memory vectors, feeds them to the MAC with the running accumulator as the addend, then writes the final accumulator to a destination address. It sits between the core's memory port and the MAC unit, and owns both for the duration of a job.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/accumulator width
- ADDR_WIDTH, 32, byte address width
- LEN_WIDTH, 8, element count width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  job request, sampled only in IDLE
- src_a_base  in  ADDR_WIDTH  vector A base (word-aligned)
- src_b_base  in  ADDR_WIDTH  vector B base (word-aligned)
- dst_addr  in  ADDR_WIDTH  result address
- length  in  LEN_WIDTH  element count N
- mode_cfg  in  2  MAC mode for the job
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion
- ovf_sticky  out  1  OR of mac_overflow|mac_underflow over the job
- mem_addr  out  ADDR_WIDTH  memory address
- mem_read / mem_write  out  1  request strobes, mutually exclusive
- mem_data_out  out  DATA_WIDTH  write data
- mem_data_in  in  DATA_WIDTH  read data, valid with mem_valid
- mem_valid  in  1  completes the current request
- mac_a, mac_b, mac_c  out  DATA_WIDTH  MAC operands/addend
- mac_mode  out  2  latched mode_cfg
- mac_enable  out  1  MAC strobe
- mac_result  in  DATA_WIDTH  MAC output, combinational from mac_a/b/c
- mac_overflow, mac_underflow  in  1  MAC flags

## Operation
- States: IDLE, RD_A, RD_B, MAC, WR, DONE.
- IDLE: on start, latch bases, dst_addr, length and mode_cfg. Clear idx, acc and ovf_sticky. Go to RD_A, or to WR if length==0.
- RD_A: mem_read=1, mem_addr=src_a_base+4*idx. On mem_valid, latch op_a and go to RD_B. Otherwise hold with stable address.
- RD_B: same as RD_A for src_b_base, latching op_b. On mem_valid, go to MAC.
- MAC: one cycle. mac_enable=1, mac_a=op_a, mac_b=op_b, mac_c=acc. Then acc<=mac_result, ovf_sticky|=overflow|underflow, idx<=idx+1. Go to WR if idx==length-1, else RD_A.
- WR: mem_write=1, mem_addr=dst_addr, mem_data_out=acc. Hold until mem_valid, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH. Wrap past the top is silent.
- Maximum N is 2^LEN_WIDTH-1. idx is LEN_WIDTH wide.
- start outside IDLE is ignored. mem_valid outside RD_A/RD_B/WR is ignored.
- ovf_sticky holds after DONE until the next accepted start.
- mac_a/b/c and mem_addr/mem_data_out are don't-care while their strobe is low. The implementation drives them to 0.

## Timing
- Reset value of every output is 0. Internal state resets to IDLE, acc=0, idx=0. Reset applies immediately on rst_n low, including mid-job; no write is issued.
- Cycle 0 is the edge that accepts start. With zero-wait memory (mem_valid in the same cycle as the request), each element takes 3 cycles.
- WR occupies cycle 3N+1, and done is high in cycle 3N+2.
- Each wait cycle on mem_valid adds one cycle.
- busy rises the cycle after start is accepted and falls the cycle after done.
- The earliest next start is sampled in the cycle after done.

## Configuration
- DSP_SEQ_ABORT_EN defined: adds input `abort` (1 bit).
  - abort high in any non-IDLE state forces IDLE at the next edge.
  - All strobes drop, no write is issued, done is not pulsed, and ovf_sticky is held.
  - An outstanding memory request is abandoned; the memory side must tolerate this.
- DSP_SEQ_ABORT_EN undefined: the port is absent and jobs always run to DONE.

## Test plan
- N=3, A={1,2,3}, B={4,5,6}, zero-wait memory, behavioural MAC a*b+c -> write 32 to dst_addr in cycle 10, done in cycle 11, ovf_sticky=0.
- N=0 -> write of 0 to dst_addr in cycle 1, done in cycle 2, no mem_read or mac_enable ever asserted.
- N=2, A={5,6}, B={7,8}, every read stalls 2 cycles -> write 83, done in cycle 8+8=16, mem_addr stable during each stall.
- MAC model asserts mac_overflow on element 1 of 4 -> ovf_sticky=1 from the cycle after that MAC cycle through DONE; a new start clears it.
- rst_n low during RD_B of element 2 -> all outputs 0 asynchronously, no write; after release, a new N=1 job (3,4) writes 12.
- With DSP_SEQ_ABORT_EN: abort in MAC of element 1 of N=4 -> IDLE next cycle, busy=0, no write, done never pulses.
